// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Registered ALU with valid/ready handshakes on both sides.
//             Single-cycle ops (add/sub/logic/compare/shift) answer one
//             clock after acceptance. Multiply is a shift-add loop of
//             WIDTH steps and is present only when ALU_SEQ_MUL_EN is
//             defined; otherwise opcode 10 reports as unsupported.
//  Build    : `define ALU_SEQ_MUL_EN to include the iterative multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] rega,
    input  logic [WIDTH-1:0] regb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;

`ifdef ALU_SEQ_MUL_EN
    // Multiplicand shifts left and multiplier shifts right each step, so
    // step i adds (A << i) whenever bit i of B is set.
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_next;
`endif

    // Single-cycle ALU function of the live inputs
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   alu_sum;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic [SHW-1:0]   shamt;

    assign shamt = regb[SHW-1:0];

    // Combinational result/flags for every non-iterative opcode
    always_comb begin
        alu_res   = '0;
        alu_sum   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_sum   = {1'b0, rega} + {1'b0, regb};
                alu_res   = alu_sum[WIDTH-1:0];
                alu_carry = alu_sum[WIDTH];
                alu_ovf   = (rega[MSB] == regb[MSB]) && (alu_res[MSB] != rega[MSB]);
            end
            OP_SUB: begin
                // A + ~B + 1: the carry out is the inverse of the borrow
                alu_sum   = {1'b0, rega} + {1'b0, ~regb} + {{WIDTH{1'b0}}, 1'b1};
                alu_res   = alu_sum[WIDTH-1:0];
                alu_carry = alu_sum[WIDTH];
                alu_ovf   = (rega[MSB] != regb[MSB]) && (alu_res[MSB] != rega[MSB]);
            end
            OP_AND:  alu_res = rega & regb;
            OP_OR:   alu_res = rega | regb;
            OP_XOR:  alu_res = rega ^ regb;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (rega < regb)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rega) < $signed(regb))};
            OP_SLL:  alu_res = rega << shamt;
            OP_SRL:  alu_res = rega >> shamt;
            OP_SRA:  alu_res = $signed(rega) >>> shamt;
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    // Next-state, datapath capture and handshake sequencing
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        err_d      = err_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (opcode == OP_MUL) begin
                        mcand_d  = rega;
                        mplier_d = regb;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
`else
                    begin
`endif
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        carry_d    = alu_carry;
                        overflow_d = alu_ovf;
                        err_d      = alu_err;
                        state_d    = DONE;
                    end
                end
            end
            MUL: begin
`ifdef ALU_SEQ_MUL_EN
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = acc_next;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d   = acc_next;
                    zero_d     = (acc_next == '0);
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign err       = err_q;

endmodule
`default_nettype wire
